// File: rtl/pipe_hazard_if.sv
// Pipeline-to-hazard-controller bundle: hazard sources from ID/EXE/MEM in,
// register enables, bubbles and forwarding selects out.
interface pipe_hazard_if;
  logic [4:0] id_rs_addr;
  logic [4:0] id_rt_addr;
  logic       id_rs_used;
  logic       id_rt_used;
  logic       id_branch_taken;
  logic [4:0] exe_rf_waddr;
  logic       exe_rf_wena;
  logic       exe_is_load;
  logic       exe_mc_start;
  logic [4:0] mem_rf_waddr;
  logic       mem_rf_wena;
  logic       pc_wena;
  logic       if_id_wena;
  logic       if_id_flush;
  logic       id_exe_wena;
  logic       id_exe_bubble;
  logic       exe_mem_bubble;
  logic [1:0] fwd_rs_sel;
  logic [1:0] fwd_rt_sel;

  modport master (
    output id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_branch_taken,
           exe_rf_waddr, exe_rf_wena, exe_is_load, exe_mc_start,
           mem_rf_waddr, mem_rf_wena,
    input  pc_wena, if_id_wena, if_id_flush, id_exe_wena, id_exe_bubble,
           exe_mem_bubble, fwd_rs_sel, fwd_rt_sel
  );

  modport slave (
    input  id_rs_addr, id_rt_addr, id_rs_used, id_rt_used, id_branch_taken,
           exe_rf_waddr, exe_rf_wena, exe_is_load, exe_mc_start,
           mem_rf_waddr, mem_rf_wena,
    output pc_wena, if_id_wena, if_id_flush, id_exe_wena, id_exe_bubble,
           exe_mem_bubble, fwd_rs_sel, fwd_rt_sel
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard/stall/flush sequencing for the 5-stage pipeline. Define PIPE_FWD_EN to
// enable EXE/MEM forwarding (stall only on load-use); otherwise any RAW match stalls.
// All pipeline handshakes are level-based: enables/bubbles act in the same cycle they are driven.
module pipe_hazard_ctrl #(
  parameter int MC_LAT = 4,
  parameter int CNT_W  = 32
) (
  input  logic             clk,
  input  logic             rst,
  pipe_hazard_if.slave     hz,
  output logic             mc_busy,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int MC_W = (MC_LAT > 2) ? $clog2(MC_LAT - 1) : 1;
  localparam logic [MC_W-1:0] MC_INIT = MC_W'((MC_LAT > 2) ? (MC_LAT - 2) : 0);

  typedef enum logic {IDLE, MC_BUSY} state_t;

  state_t          state, state_next;
  logic [MC_W-1:0] mc_cnt, mc_cnt_next;
  logic            mc_stall;
  logic            data_stall;
  logic            exe_rs_hit, exe_rt_hit, mem_rs_hit, mem_rt_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      mc_cnt <= '0;
    end else begin
      state  <= state_next;
      mc_cnt <= mc_cnt_next;
    end
  end

  // IDLE claims the first stall cycle; MC_BUSY covers the rest plus the release cycle.
  always_comb begin
    state_next  = state;
    mc_cnt_next = mc_cnt;
    mc_stall    = 1'b0;
    case (state)
      IDLE: begin
        if (hz.exe_mc_start && (MC_LAT > 1)) begin
          mc_stall    = 1'b1;
          mc_cnt_next = MC_INIT;
          state_next  = MC_BUSY;
        end
      end
      MC_BUSY: begin
        if (mc_cnt != '0) begin
          mc_stall    = 1'b1;
          mc_cnt_next = mc_cnt - 1'b1;
        end else begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  assign mc_busy = (state == MC_BUSY);

  // Register $0 is hard-wired, so it never creates a dependency.
  assign exe_rs_hit = hz.id_rs_used && (hz.id_rs_addr != 5'd0) &&
                      (hz.id_rs_addr == hz.exe_rf_waddr) && hz.exe_rf_wena;
  assign exe_rt_hit = hz.id_rt_used && (hz.id_rt_addr != 5'd0) &&
                      (hz.id_rt_addr == hz.exe_rf_waddr) && hz.exe_rf_wena;
  assign mem_rs_hit = hz.id_rs_used && (hz.id_rs_addr != 5'd0) &&
                      (hz.id_rs_addr == hz.mem_rf_waddr) && hz.mem_rf_wena;
  assign mem_rt_hit = hz.id_rt_used && (hz.id_rt_addr != 5'd0) &&
                      (hz.id_rt_addr == hz.mem_rf_waddr) && hz.mem_rf_wena;

`ifdef PIPE_FWD_EN
  logic [1:0] rs_sel, rt_sel;
  assign rs_sel     = (exe_rs_hit && !hz.exe_is_load) ? 2'b01 : (mem_rs_hit ? 2'b10 : 2'b00);
  assign rt_sel     = (exe_rt_hit && !hz.exe_is_load) ? 2'b01 : (mem_rt_hit ? 2'b10 : 2'b00);
  assign data_stall = (exe_rs_hit || exe_rt_hit) && hz.exe_is_load;
`else
  logic [1:0] rs_sel, rt_sel;
  logic       unused_is_load;
  assign rs_sel         = 2'b00;
  assign rt_sel         = 2'b00;
  assign unused_is_load = hz.exe_is_load;
  assign data_stall     = exe_rs_hit || exe_rt_hit || mem_rs_hit || mem_rt_hit;
`endif

  always_comb begin
    hz.pc_wena        = 1'b1;
    hz.if_id_wena     = 1'b1;
    hz.id_exe_wena    = 1'b1;
    hz.id_exe_bubble  = 1'b0;
    hz.exe_mem_bubble = 1'b0;
    hz.if_id_flush    = 1'b0;
    hz.fwd_rs_sel     = rs_sel;
    hz.fwd_rt_sel     = rt_sel;
    if (rst) begin
      hz.pc_wena        = 1'b0;
      hz.if_id_wena     = 1'b0;
      hz.id_exe_wena    = 1'b0;
      hz.id_exe_bubble  = 1'b1;
      hz.exe_mem_bubble = 1'b1;
      hz.if_id_flush    = 1'b1;
      hz.fwd_rs_sel     = 2'b00;
      hz.fwd_rt_sel     = 2'b00;
    end else if (mc_stall) begin
      hz.pc_wena        = 1'b0;
      hz.if_id_wena     = 1'b0;
      hz.id_exe_wena    = 1'b0;
      hz.exe_mem_bubble = 1'b1;
    end else if (data_stall) begin
      hz.pc_wena       = 1'b0;
      hz.if_id_wena    = 1'b0;
      hz.id_exe_bubble = 1'b1;
    end else begin
      hz.if_id_flush = hz.id_branch_taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!hz.pc_wena && (stall_cnt != {CNT_W{1'b1}})) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed and random stimulus for pipe_hazard_ctrl, checked cycle by cycle
// against a stage-occupancy reference model.
module tb_pipe_hazard_ctrl;
  localparam int MC_LAT = 4;
  localparam int CNT_W  = 6;
  localparam int CMAX   = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             mc_busy;
  logic [CNT_W-1:0] stall_cnt;

  pipe_hazard_if hz ();

  pipe_hazard_ctrl #(.MC_LAT(MC_LAT), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .hz        (hz),
    .mc_busy   (mc_busy),
    .stall_cnt (stall_cnt)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;
  int age = 0;      // cycle index within the current multi-cycle op, 0 = none
  int exp_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic hit(input logic u, input logic [4:0] a, input logic [4:0] d,
                               input logic we);
    return u && (a != 5'd0) && (a == d) && we;
  endfunction

  task automatic check_cycle();
    int cur;
    logic ers, ert, mrs, mrt, st_mc, st_d;
    logic e_pc, e_ifid, e_idex, e_idb, e_emb, e_fl, e_busy;
    logic [1:0] e_frs, e_frt;
    if (rst) begin
      age = 0; exp_cnt = 0; cur = 0;
      e_pc = 0; e_ifid = 0; e_idex = 0; e_idb = 1; e_emb = 1; e_fl = 1;
      e_frs = 0; e_frt = 0; e_busy = 0;
    end else begin
      cur = (age != 0) ? age : ((hz.exe_mc_start && MC_LAT > 1) ? 1 : 0);
      st_mc  = (cur >= 1) && (cur < MC_LAT);
      e_busy = (cur >= 2);
      ers = hit(hz.id_rs_used, hz.id_rs_addr, hz.exe_rf_waddr, hz.exe_rf_wena);
      ert = hit(hz.id_rt_used, hz.id_rt_addr, hz.exe_rf_waddr, hz.exe_rf_wena);
      mrs = hit(hz.id_rs_used, hz.id_rs_addr, hz.mem_rf_waddr, hz.mem_rf_wena);
      mrt = hit(hz.id_rt_used, hz.id_rt_addr, hz.mem_rf_waddr, hz.mem_rf_wena);
`ifdef PIPE_FWD_EN
      e_frs = (ers && !hz.exe_is_load) ? 2'd1 : (mrs ? 2'd2 : 2'd0);
      e_frt = (ert && !hz.exe_is_load) ? 2'd1 : (mrt ? 2'd2 : 2'd0);
      st_d  = (ers || ert) && hz.exe_is_load;
`else
      e_frs = 0; e_frt = 0;
      st_d  = ers || ert || mrs || mrt;
`endif
      if (st_mc) begin
        e_pc = 0; e_ifid = 0; e_idex = 0; e_idb = 0; e_emb = 1; e_fl = 0;
      end else if (st_d) begin
        e_pc = 0; e_ifid = 0; e_idex = 1; e_idb = 1; e_emb = 0; e_fl = 0;
      end else begin
        e_pc = 1; e_ifid = 1; e_idex = 1; e_idb = 0; e_emb = 0; e_fl = hz.id_branch_taken;
      end
    end
    chk("pc_wena", hz.pc_wena, e_pc);
    chk("if_id_wena", hz.if_id_wena, e_ifid);
    chk("id_exe_wena", hz.id_exe_wena, e_idex);
    chk("id_exe_bubble", hz.id_exe_bubble, e_idb);
    chk("exe_mem_bubble", hz.exe_mem_bubble, e_emb);
    chk("if_id_flush", hz.if_id_flush, e_fl);
    chk("fwd_rs_sel", hz.fwd_rs_sel, e_frs);
    chk("fwd_rt_sel", hz.fwd_rt_sel, e_frt);
    chk("mc_busy", mc_busy, e_busy);
    chk("stall_cnt", stall_cnt, exp_cnt);
    if (!rst) begin
      age = (cur == 0 || cur == MC_LAT) ? 0 : cur + 1;
      if (!e_pc && exp_cnt < CMAX) exp_cnt++;
    end
  endtask

  task automatic drive(input logic r,
                       input logic [4:0] rs, input logic rsu,
                       input logic [4:0] rt, input logic rtu, input logic br,
                       input logic [4:0] ew, input logic ewe, input logic eld,
                       input logic emc, input logic [4:0] mw, input logic mwe);
    @(negedge clk);
    rst = r;
    hz.id_rs_addr = rs; hz.id_rs_used = rsu;
    hz.id_rt_addr = rt; hz.id_rt_used = rtu;
    hz.id_branch_taken = br;
    hz.exe_rf_waddr = ew; hz.exe_rf_wena = ewe; hz.exe_is_load = eld;
    hz.exe_mc_start = emc;
    hz.mem_rf_waddr = mw; hz.mem_rf_wena = mwe;
    #1;
    check_cycle();
  endtask

  task automatic idle(input logic r);
    drive(r, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    hz.id_rs_addr = 0; hz.id_rs_used = 0; hz.id_rt_addr = 0; hz.id_rt_used = 0;
    hz.id_branch_taken = 0; hz.exe_rf_waddr = 0; hz.exe_rf_wena = 0;
    hz.exe_is_load = 0; hz.exe_mc_start = 0; hz.mem_rf_waddr = 0; hz.mem_rf_wena = 0;

    idle(1'b1); idle(1'b1);
    idle(1'b0); idle(1'b0);

    // reset landing in the middle of a multi-cycle op
    drive(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd0, 0);
    drive(0, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd0, 0);
    chk("t1_busy_before_rst", mc_busy, 1'b1);
    drive(1, 5'd0, 0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 5'd0, 0);
    idle(1'b0);
    chk("t1_busy_after_rst", mc_busy, 1'b0);

    // $0 never matches
    drive(0, 5'd0, 1, 5'd0, 0, 0, 5'd0, 1, 0, 0, 5'd0, 0);
    chk("t6_no_stall", hz.pc_wena, 1'b1);

    // EXE and MEM both write r5
    drive(0, 5'd5, 1, 5'd0, 0, 0, 5'd5, 1, 0, 0, 5'd5, 1);
`ifdef PIPE_FWD_EN
    chk("t2_fwd_exe_wins", hz.fwd_rs_sel, 2'b01);
`endif

    // load-use on rt=8: load in EXE, then in MEM
    idle(1'b1);
    drive(0, 5'd0, 0, 5'd8, 1, 0, 5'd8, 1, 1, 0, 5'd0, 0);
    drive(0, 5'd0, 0, 5'd8, 1, 0, 5'd0, 0, 0, 0, 5'd8, 1);
`ifdef PIPE_FWD_EN
    chk("t3_stall_cnt", stall_cnt, 1);
`endif
    idle(1'b0);

    // rs=3 dependency moving EXE -> MEM -> gone
    drive(0, 5'd3, 1, 5'd0, 0, 0, 5'd3, 1, 0, 0, 5'd0, 0);
    drive(0, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'd3, 1);
    drive(0, 5'd3, 1, 5'd0, 0, 0, 5'd0, 0, 0, 0, 5'd0, 0);

    // multi-cycle op held with a taken branch waiting in ID
    for (int i = 0; i < MC_LAT; i++)
      drive(0, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0, 1, 5'd0, 0);
    drive(0, 5'd0, 0, 5'd0, 0, 1, 5'd0, 0, 0, 0, 5'd0, 0);

    for (int i = 0; i < 600; i++) begin
      drive(($urandom_range(0, 99) == 0),
            5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
            5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 7),
            1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 7) == 0),
            5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
